universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range >= 2).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning the burst-amount width (derived, not overridden).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: single-step operation request.
REQ-006 The block SHALL have port mode, input, 3 bits: operation select.
REQ-007 The block SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-008 The block SHALL have port sin_l, input, 1 bit: serial bit entering the MSB on a logical shift right.
REQ-009 The block SHALL have port sin_r, input, 1 bit: serial bit entering the LSB on a shift left.
REQ-010 The block SHALL have port start, input, 1 bit: burst request.
REQ-011 The block SHALL have port amount, input, CNT_W bits: burst step count.
REQ-012 The block SHALL have port pout, output, WIDTH bits: register contents.
REQ-013 The block SHALL have port sout_msb, output, 1 bit: equal to pout[WIDTH-1].
REQ-014 The block SHALL have port sout_lsb, output, 1 bit: equal to pout[0].
REQ-015 The block SHALL have port busy, output, 1 bit: burst in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle burst-completion pulse.

Function
REQ-017 Mode encoding SHALL be: 000 HOLD, 001 LOAD (pout<=pin), 010 SHL (LSB<=sin_r), 011 SHR (MSB<=sin_l), 100 ROTL, 101 ROTR, 110 ASR (MSB replicated), 111 CLEAR (pout<=0).
REQ-018 In IDLE, with start=0 and enable=1, the block SHALL apply mode exactly once at the next edge; with enable=0, pout SHALL hold.
REQ-019 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch mode and amount, go to RUN, and ignore enable in that cycle (start wins).
REQ-021 A latched amount greater than WIDTH SHALL be clamped to WIDTH.
REQ-022 A latched amount of 0 SHALL cause the FSM to go directly to DONE with pout unchanged.
REQ-023 In RUN, the block SHALL apply the latched mode once per cycle for amount cycles.
REQ-024 During RUN, busy SHALL be 1, and both enable and start SHALL be ignored.
REQ-025 During RUN, the serial inputs SHALL be sampled live each cycle.
REQ-026 After the final RUN step the FSM SHALL enter DONE, in which done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-027 A start asserted while in DONE SHALL be ignored.
REQ-028 Burst latency for N steps SHALL be: busy for N cycles beginning the cycle after start, and done in cycle N+1.
REQ-029 sout_msb and sout_lsb SHALL be combinational from the register, with no added latency.

Reset
REQ-030 When rst=0, the block SHALL immediately (asynchronously) force pout=0, busy=0, done=0, FSM=IDLE and the internal count to 0.
REQ-031 Reset asserted during RUN SHALL abort the burst with no done pulse.
REQ-032 After rst deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-033 With macro UNIV_SR_ROTATE_EN defined, modes 100 and 101 SHALL rotate left and right respectively.
REQ-034 Without UNIV_SR_ROTATE_EN, modes 100 and 101 SHALL behave as HOLD in both single-step and burst, and a burst with them SHALL still run its cycles and pulse done.

Structure
REQ-035 Package univ_sr_pkg SHALL hold the mode encoding constants and the FSM state typedef.
REQ-036 Sub-module univ_sr_step SHALL compute the next register value from current value, mode, sin_l and sin_r (combinational).
REQ-037 The top level SHALL own the register, FSM and counter.

Verification (WIDTH=8)
REQ-038 Scenario: assert rst=0 mid-cycle during activity -> pout=00, busy=0 and done=0 immediately, without waiting for a clock edge.
REQ-039 Scenario: enable=1, LOAD, pin=A5 -> pout=A5 after one edge; then enable=0, pin=5A -> pout remains A5.
REQ-040 Scenario: from pout=A5, single-step SHL with sin_r=1 -> 4B; from A5, SHR with sin_l=0 -> 52; from A5, ASR -> D2; CLEAR -> 00.
REQ-041 Scenario: macro defined, pout=81, start with ROTL and amount=3 -> busy for 3 cycles, pout 03, 06, 0C, then done for 1 cycle; enable pulses during busy have no effect.
REQ-042 Scenario: amount=0 -> done on the next cycle with busy never set and pout unchanged; amount=12, SHL, sin_r=0, pout=FF -> 8 steps, then pout=00 and done.
REQ-043 Scenario: reset asserted at RUN step 2 -> pout=00 and no done pulse; with the macro undefined, a ROTL burst of 2 -> pout unchanged and done pulses.

Source files
------------

// File: rtl/univ_sr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit mode encoding and the burst FSM state type.
// Optional feature macro: UNIV_SR_ROTATE_EN (used in univ_sr_step).
package univ_sr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/univ_sr_step.sv
// Combinational next-value function of the universal shift register.
// Ports:
//   cur_i   - current register value
//   mode_i  - operation select
//   pin_i   - parallel load data
//   sin_l_i - serial bit entering the MSB on a logical shift right
//   sin_r_i - serial bit entering the LSB on a shift left
//   nxt_o   - register value after one step of mode_i
// Macro UNIV_SR_ROTATE_EN: when defined, ROTL/ROTR rotate; otherwise they hold.
module univ_sr_step
  import univ_sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (mode_i)
      MODE_HOLD:  nxt_o = cur_i;
      MODE_LOAD:  nxt_o = pin_i;
      MODE_SHL:   nxt_o = {cur_i[WIDTH-2:0], sin_r_i};
      MODE_SHR:   nxt_o = {sin_l_i, cur_i[WIDTH-1:1]};
`ifdef UNIV_SR_ROTATE_EN
      MODE_ROTL:  nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      MODE_ROTR:  nxt_o = {cur_i[0], cur_i[WIDTH-1:1]};
`else
      MODE_ROTL:  nxt_o = cur_i;
      MODE_ROTR:  nxt_o = cur_i;
`endif
      MODE_ASR:   nxt_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      MODE_CLEAR: nxt_o = '0;
      default:    nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-step and counted-burst operation.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   enable   - apply mode once at the next edge (IDLE only)
//   mode     - operation select (see univ_sr_pkg::mode_e)
//   pin      - parallel load data
//   sin_l    - serial in to MSB on shift right
//   sin_r    - serial in to LSB on shift left
//   start    - burst request (IDLE only, wins over enable)
//   amount   - burst step count, clamped to WIDTH
//   pout     - register contents
//   sout_msb - pout[WIDTH-1]
//   sout_lsb - pout[0]
//   busy     - burst in progress
//   done     - one-cycle burst completion pulse
// Macro UNIV_SR_ROTATE_EN enables the rotate modes (see univ_sr_step).
module universal_shift_reg
  import univ_sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] pout,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  state_e           state_q, state_d;

  mode_e            step_mode;
  logic [WIDTH-1:0] step_nxt;
  logic [CNT_W-1:0] amt_clamped;

  assign amt_clamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  // In RUN the latched mode drives the step; otherwise the live mode does.
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode_e'(mode);

  univ_sr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .cur_i   (pout_q),
    .mode_i  (step_mode),
    .pin_i   (pin),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .nxt_o   (step_nxt)
  );

  always_comb begin
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          cnt_d   = amt_clamped;
          state_d = (amt_clamped == '0) ? ST_DONE : ST_RUN;
        end else if (enable) begin
          pout_d = step_nxt;
        end
      end
      ST_RUN: begin
        pout_d = step_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      state_q <= ST_IDLE;
    end else begin
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      state_q <= state_d;
    end
  end

  assign pout     = pout_q;
  assign sout_msb = pout_q[WIDTH-1];
  assign sout_lsb = pout_q[0];
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8).
// A reference model advances with every driven cycle and pushes the
// expected outputs into a scoreboard queue; entries are popped and
// compared one time unit after the clock edge.
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    mode;
  logic [W-1:0]  pin;
  logic          sin_l;
  logic          sin_r;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  pout;
  logic          sout_msb;
  logic          sout_lsb;
  logic          busy;
  logic          done;

  universal_shift_reg #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .pin      (pin),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .start    (start),
    .amount   (amount),
    .pout     (pout),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] pout;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  logic [W-1:0] m_pout;
  int           m_state;
  int           m_cnt;
  logic [2:0]   m_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input logic [2:0] md,
                                            input logic [W-1:0] p, input logic sl, input logic sr);
    case (md)
      3'd0: return v;
      3'd1: return p;
      3'd2: return (v << 1) | W'(sr);
      3'd3: return (v >> 1) | (W'(sl) << (W - 1));
`ifdef UNIV_SR_ROTATE_EN
      3'd4: return (v << 1) | (v >> (W - 1));
      3'd5: return (v >> 1) | (v << (W - 1));
`else
      3'd4: return v;
      3'd5: return v;
`endif
      3'd6: return (v >> 1) | (v & (W'(1) << (W - 1)));
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_pout  = '0;
    m_state = 0;
    m_cnt   = 0;
    m_mode  = 3'd0;
  endtask

  task automatic model_edge();
    int a;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        if (start) begin
          a      = (int'(amount) > W) ? W : int'(amount);
          m_mode = mode;
          m_cnt  = a;
          m_state = (a == 0) ? 2 : 1;
        end else if (enable) begin
          m_pout = ref_step(m_pout, mode, pin, sin_l, sin_r);
        end
      end
      1: begin
        m_pout = ref_step(m_pout, m_mode, pin, sin_l, sin_r);
        m_cnt--;
        if (m_cnt == 0) m_state = 2;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.pout = m_pout;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".pout"}, 32'(pout), 32'(e.pout));
    check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({e.tag, ".done"}, 32'(done), 32'(e.done));
    check({e.tag, ".msb"},  32'(sout_msb), 32'(e.pout[W-1]));
    check({e.tag, ".lsb"},  32'(sout_lsb), 32'(e.pout[0]));
  endtask

  task automatic tick(input string tag);
    model_edge();
    push_exp(tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic load(input logic [W-1:0] v);
    enable = 1'b1; mode = 3'd1; pin = v; start = 1'b0;
    tick("load");
    enable = 1'b0;
  endtask

  task automatic burst(input string tag, input logic [2:0] md, input int n, input int cycles);
    start = 1'b1; mode = md; amount = CW'(n); enable = 1'b0;
    tick({tag, ".start"});
    start = 1'b0;
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; mode = 3'd0; pin = '0;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; amount = '0;
    #1;
    model_reset();
    push_exp("reset");
    compare_head();
    tick("reset_hold");
    rst = 1'b1;

    // Single-step operations
    load(8'hA5);
    enable = 1'b0; mode = 3'd1; pin = 8'h5A;
    tick("hold_en0");
    enable = 1'b1; mode = 3'd0;
    tick("hold_mode");
    enable = 1'b1; mode = 3'd2; sin_r = 1'b1;
    tick("shl");
    load(8'hA5);
    enable = 1'b1; mode = 3'd3; sin_l = 1'b0;
    tick("shr");
    load(8'hA5);
    enable = 1'b1; mode = 3'd6;
    tick("asr");
    enable = 1'b1; mode = 3'd7;
    tick("clear");
    enable = 1'b0; sin_r = 1'b0;

    // ROTL burst of 3 with enable/start noise during RUN and start in DONE
    load(8'h81);
    start = 1'b1; mode = 3'd4; amount = CW'(3);
    tick("rotl.start");
    start = 1'b0; enable = 1'b1; mode = 3'd7;
    tick("rotl.s1");
    start = 1'b1; mode = 3'd1; pin = 8'h00;
    tick("rotl.s2");
    start = 1'b0; enable = 1'b0;
    tick("rotl.s3");
    start = 1'b1; mode = 3'd7; amount = CW'(2);
    tick("rotl.done");
    start = 1'b0;
    tick("rotl.idle");

    // Zero-length burst
    burst("amt0", 3'd2, 0, 1);

    // Over-length burst clamps to WIDTH
    load(8'hFF);
    sin_r = 1'b0;
    burst("amt12", 3'd2, 12, 10);

    // Serial input sampled live during RUN
    load(8'h00);
    start = 1'b1; mode = 3'd3; amount = CW'(4);
    tick("live.start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin_l = (i != 1);
      tick("live");
    end
    tick("live.done");
    sin_l = 1'b0;

    // Reset in the middle of a burst
    load(8'h3C);
    sin_r = 1'b1;
    start = 1'b1; mode = 3'd2; amount = CW'(5);
    tick("abort.start");
    start = 1'b0;
    tick("abort.s1");
    tick("abort.s2");
    #2 rst = 1'b0;
    #1;
    model_reset();
    push_exp("abort.async");
    compare_head();
    tick("abort.hold");
    rst = 1'b1;
    tick("abort.post");
    tick("abort.post2");
    load(8'h99);
    sin_r = 1'b0;

    // ROTR burst of 2
    load(8'h81);
    burst("rotr", 3'd5, 2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
